// File: rtl/lc3b_types.sv
// Shared LC-3b types used by the memory arbiter and its neighbours.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } lc3b_arb_state;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two caches, the arbiter and physical memory.
//
// Handshake: a requester raises x_read/x_write with address (and wdata) and
// holds them stable until it sees x_resp high for one cycle; x_rdata is only
// meaningful in that cycle. Physical memory sees pmem_read/pmem_write held
// until it answers with a single-cycle pmem_resp carrying pmem_rdata.
interface mem_arbiter_if;
  import lc3b_types::*;

  logic     i_read;
  lc3b_word i_address;
  logic     i_resp;
  lc3b_line i_rdata;

  logic     d_read;
  logic     d_write;
  lc3b_word d_address;
  lc3b_line d_wdata;
  logic     d_resp;
  lc3b_line d_rdata;

  logic     pmem_read;
  logic     pmem_write;
  lc3b_word pmem_address;
  lc3b_line pmem_wdata;
  logic     pmem_resp;
  lc3b_line pmem_rdata;

  // Arbiter side.
  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_resp, pmem_rdata,
    output i_resp, i_rdata, d_resp, d_rdata,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  // Environment side: caches and physical memory.
  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_resp, pmem_rdata,
    input  i_resp, i_rdata, d_resp, d_rdata,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );

endinterface

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive D grants taken while I was waiting.
module arb_starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [3:0] LIMIT_W = 4'(LIMIT);

  logic [3:0] count;

  // Clear wins over increment; increment stops once the limit is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (clr) begin
      count <= 4'd0;
    end else if (inc && (count != LIMIT_W)) begin
      count <= count + 4'd1;
    end
  end

  assign at_limit = (count == LIMIT_W);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one physical-memory port between the I cache and the D cache.
// D wins ties (older instruction) until the starvation limit forces I.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus,
  output logic          busy,
  output lc3b_arb_state dbg_state
);

  lc3b_arb_state state, next_state;
  logic d_req;
  logic inc, clr, at_limit;

  assign d_req = bus.d_read | bus.d_write;

  // Both caches see the memory line; only their resp qualifies it.
  assign bus.i_rdata = bus.pmem_rdata;
  assign bus.d_rdata = bus.pmem_rdata;

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // State register; reset drops any grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state, bus muxing and streak control.
  always_comb begin
    next_state       = state;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    bus.i_resp       = 1'b0;
    bus.d_resp       = 1'b0;
    inc              = 1'b0;
    clr              = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && bus.i_read) begin
          next_state = at_limit ? SERVE_I : SERVE_D;
        end else if (d_req) begin
          next_state = SERVE_D;
        end else if (bus.i_read) begin
          next_state = SERVE_I;
        end
        inc = (next_state == SERVE_D) && bus.i_read;
        clr = (next_state == SERVE_I);
      end
      SERVE_I: begin
        // Command follows the requester even if it drops early; grant holds.
        bus.pmem_read    = bus.i_read;
        bus.pmem_address = bus.i_address;
        if (bus.pmem_resp) begin
          bus.i_resp = 1'b1;
          next_state = IDLE;
        end
      end
      SERVE_D: begin
        bus.pmem_read    = bus.d_read;
        bus.pmem_write   = bus.d_write;
        bus.pmem_address = bus.d_address;
        bus.pmem_wdata   = bus.d_wdata;
        if (bus.pmem_resp) begin
          bus.d_resp = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  arb_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (inc),
    .clr      (clr),
    .at_limit (at_limit)
  );

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port physical-memory arbiter for the pipelined LC-3b core. It shares a single physical-memory port between the instruction-fetch cache (I side) and the data cache (D side). On simultaneous misses it grants the D side by default, because the data access belongs to the older instruction. A starvation counter forces an I grant after a bounded run of D grants.

## Interface
Parameters:
- STARVE_LIMIT, 4: maximum number of consecutive D grants made while an I request is pending before I is forced; legal range 1–15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i_read  input  1  I-side line read request; held until i_resp.
- i_address  input  16  I-side byte address (lc3b_word).
- i_resp  output  1  I-side transaction complete.
- i_rdata  output  128  I-side read line (lc3b_line).
- d_read  input  1  D-side line read request.
- d_write  input  1  D-side line write request; never asserted together with d_read.
- d_address  input  16  D-side byte address.
- d_wdata  input  128  D-side write line.
- d_resp  output  1  D-side transaction complete.
- d_rdata  output  128  D-side read line.
- pmem_read  output  1  physical-memory read command.
- pmem_write  output  1  physical-memory write command.
- pmem_address  output  16  physical-memory address.
- pmem_wdata  output  128  physical-memory write line.
- pmem_resp  input  1  physical-memory completion; one-cycle pulse.
- pmem_rdata  input  128  physical-memory read line; valid when pmem_resp is high.
- busy  output  1  high in any state other than IDLE.

## Operation
- State machine lc3b_arb_state has three states: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - No request pending → stay in IDLE.
  - Only D requests (d_read|d_write) → SERVE_D.
  - Only I requests → SERVE_I.
  - Both request → SERVE_D, unless streak == STARVE_LIMIT; then SERVE_I.
- SERVE_x:
  - pmem_read, pmem_write, pmem_address and pmem_wdata are driven combinationally from the granted side's inputs.
  - The I side always drives pmem_write=0 and pmem_wdata=0.
  - On pmem_resp: pulse x_resp combinationally in the same cycle and return to IDLE on the next edge.
- Grant is locked until pmem_resp. If a requester deasserts mid-transaction it is a protocol violation. The arbiter then keeps its grant and waits for pmem_resp, but pmem_read and pmem_write follow the requester's inputs.
- i_rdata and d_rdata both carry pmem_rdata continuously. Only the x_resp signal qualifies which side the data belongs to.
- The non-granted resp output is always 0. In IDLE, all pmem_* outputs are 0.
- Streak counter (4 bits, saturating at STARVE_LIMIT):
  - Increments on each IDLE→SERVE_D transition taken while i_read=1.
  - Clears on each IDLE→SERVE_I transition.
  - Holds otherwise.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): state=IDLE, streak=0. All outputs 0: pmem_read, pmem_write, pmem_address, pmem_wdata, i_resp, d_resp, busy. The rdata outputs follow pmem_rdata.
- Arbitration latency is 1 cycle. A request seen in IDLE at edge N produces the pmem command from cycle N+1.
- If pmem_resp arrives at cycle M, x_resp is high in cycle M and state is IDLE in cycle M+1.
- At least one IDLE cycle separates back-to-back grants, so a requester has one cycle to deassert after its resp.
- Minimum transaction length is 2 cycles: 1 cycle of arbitration plus a 1-cycle pmem_resp.
- pmem_resp while in IDLE is ignored and produces no resp output.
- rst_n asserted mid-transaction returns the block to IDLE immediately, drops pmem commands the same cycle and clears streak. The requester must re-issue.

## Structure
- lc3b_types gains:
  - lc3b_line (128-bit)
  - enum lc3b_arb_state {IDLE, SERVE_I, SERVE_D}
- lc3b_word is already present in lc3b_types.
- One sub-module, arb_starve_counter: saturating counter with inc, clr and limit-compare output (at_limit). The FSM and muxing remain in mem_arbiter.

## Test plan
- Lone I read: i_read=1 with i_address=0x1230 for 1 cycle in IDLE, pmem_resp on the 3rd serve cycle with rdata=0xDEAD…BEEF → pmem_read=1 and pmem_address=0x1230 from cycle 1; i_resp=1 with that data in cycle 3; d_resp=0 throughout.
- Lone D write: d_write=1, d_address=0x4000, d_wdata=0x…55AA → pmem_write=1 with matching address and wdata; d_resp pulses for one cycle alongside pmem_resp; pmem_read=0 throughout.
- Simultaneous: i_read and d_read both asserted in IDLE with streak=0 → SERVE_D first, then IDLE for 1 cycle, then SERVE_I; streak=0 after the I grant.
- Starvation, STARVE_LIMIT=2: hold i_read high and re-issue d_read after each d_resp → exactly 2 D grants, then an I grant, then D grants resume.
- Reset mid-transaction: rst_n pulled low during SERVE_I → pmem_read=0 and busy=0 in the same cycle; a subsequent pmem_resp produces no i_resp.
- Stray pmem_resp in IDLE → i_resp=0, d_resp=0, state stays IDLE.
